// File: rtl/commit_trace_queue.sv
// Purpose: staged {PC, IR} capture feeding a small in-order queue; commit retires the head into trace outputs.
// Latency: one falling edge from push to visible occupancy, one falling edge from commit to commit_*_out.
// Backpressure: no stall; a push into a full queue without a commit is dropped and flagged via sticky overflow.
//
// Ports:
//   clk, rst                       falling-edge clock, asynchronous active-low reset
//   pc_in, ir_in                   fetch-side PC / IR
//   capture_pc, capture_ir         load pc_in / ir_in into the staged registers
//   push, commit, flush            enqueue staged pair, retire head, discard queue
//   staged_pc_out                  current staged PC
//   commit_pc_out, commit_ir_out   last retired pair; commit_valid once any retirement happened
//   occupancy, full, empty         queue fill state (register-derived only)
//   retire_count                   32-bit wrapping retirement counter
//   overflow, underflow            sticky error flags, cleared only by reset
module commit_trace_queue #(
  parameter int unsigned    W        = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [W-1:0]   RESET_PC = W'(32'h0040_0000),
  parameter logic [W-1:0]   PC_DIRTY = W'(32'h4443_6040),
  parameter logic [W-1:0]   IR_DIRTY = W'(32'h8880_7704)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             pc_in,
  input  logic [W-1:0]             ir_in,
  input  logic                     capture_pc,
  input  logic                     capture_ir,
  input  logic                     push,
  input  logic                     commit,
  input  logic                     flush,
  output logic [W-1:0]             staged_pc_out,
  output logic [W-1:0]             commit_pc_out,
  output logic [W-1:0]             commit_ir_out,
  output logic                     commit_valid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty,
  output logic [31:0]              retire_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Staged fetch registers
  logic [W-1:0]  staged_pc_q, staged_pc_d;
  logic [W-1:0]  staged_ir_q, staged_ir_d;

  // Queue storage and bookkeeping
  logic [W-1:0]  pc_mem_q [DEPTH];
  logic [W-1:0]  ir_mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d;

  // Retirement trace state
  logic [W-1:0]  commit_pc_q, commit_pc_d;
  logic [W-1:0]  commit_ir_q, commit_ir_d;
  logic          commit_vld_q, commit_vld_d;
  logic [31:0]   retire_cnt_q, retire_cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          q_empty, q_full;
  logic          do_push, do_commit;

  // All decisions look at occupancy held before the edge.
  assign q_empty = (occ_q == '0);
  assign q_full  = (occ_q == CW'(DEPTH));

  // Flush wins over everything queue-related. A commit into an empty queue is
  // ignored even with a simultaneous push; a push into a full queue only
  // lands if the head is leaving on the same edge.
  assign do_commit = commit && !q_empty && !flush;
  assign do_push   = push && !flush && (!q_full || commit);

  always_comb begin
    staged_pc_d  = staged_pc_q;
    staged_ir_d  = staged_ir_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    occ_d        = occ_q;
    commit_pc_d  = commit_pc_q;
    commit_ir_d  = commit_ir_q;
    commit_vld_d = commit_vld_q;
    retire_cnt_d = retire_cnt_q;
    ovf_d        = ovf_q;
    udf_d        = udf_q;

    // Captures are independent of the queue, including on flush edges.
    if (capture_pc) staged_pc_d = pc_in;
    if (capture_ir) staged_ir_d = ir_in;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (commit && q_empty)          udf_d = 1'b1;
      if (push && q_full && !commit)  ovf_d = 1'b1;

      if (do_commit) begin
        commit_pc_d  = pc_mem_q[rd_ptr_q];
        commit_ir_d  = ir_mem_q[rd_ptr_q];
        commit_vld_d = 1'b1;
        retire_cnt_d = retire_cnt_q + 32'd1;
        rd_ptr_d     = rd_ptr_q + AW'(1);   // power-of-two depth: natural wrap
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (do_push && !do_commit)      occ_d = occ_q + CW'(1);
      else if (do_commit && !do_push) occ_d = occ_q - CW'(1);
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      staged_pc_q  <= RESET_PC;
      staged_ir_q  <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      commit_pc_q  <= PC_DIRTY;
      commit_ir_q  <= IR_DIRTY;
      commit_vld_q <= 1'b0;
      retire_cnt_q <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      staged_pc_q  <= staged_pc_d;
      staged_ir_q  <= staged_ir_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      commit_pc_q  <= commit_pc_d;
      commit_ir_q  <= commit_ir_d;
      commit_vld_q <= commit_vld_d;
      retire_cnt_q <= retire_cnt_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  // Entry storage needs no reset: pointers and occupancy define what is live.
  // The write uses the staged values held before this edge, so a capture on
  // the same edge is not enqueued.
  always_ff @(negedge clk) begin
    if (do_push) begin
      pc_mem_q[wr_ptr_q] <= staged_pc_q;
      ir_mem_q[wr_ptr_q] <= staged_ir_q;
    end
  end

  assign staged_pc_out = staged_pc_q;
  assign commit_pc_out = commit_pc_q;
  assign commit_ir_out = commit_ir_q;
  assign commit_valid  = commit_vld_q;
  assign occupancy     = occ_q;
  assign full          = q_full;
  assign empty         = q_empty;
  assign retire_count  = retire_cnt_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Purpose: self-checking bench for commit_trace_queue against a queue-based reference model.
// Latency: outputs compared 2 time units after each falling clock edge.
// Backpressure: none; stimulus is driven freely, the model tracks dropped pushes.
module tb_commit_trace_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b1;
  logic          rst = 1'b1;
  logic [W-1:0]  pc_in = '0;
  logic [W-1:0]  ir_in = '0;
  logic          capture_pc = 1'b0;
  logic          capture_ir = 1'b0;
  logic          push = 1'b0;
  logic          commit = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  staged_pc_out;
  logic [W-1:0]  commit_pc_out;
  logic [W-1:0]  commit_ir_out;
  logic          commit_valid;
  logic [2:0]    occupancy;
  logic          full;
  logic          empty;
  logic [31:0]   retire_count;
  logic          overflow;
  logic          underflow;

  int tests = 0;
  int fails = 0;

  commit_trace_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .ir_in         (ir_in),
    .capture_pc    (capture_pc),
    .capture_ir    (capture_ir),
    .push          (push),
    .commit        (commit),
    .flush         (flush),
    .staged_pc_out (staged_pc_out),
    .commit_pc_out (commit_pc_out),
    .commit_ir_out (commit_ir_out),
    .commit_valid  (commit_valid),
    .occupancy     (occupancy),
    .full          (full),
    .empty         (empty),
    .retire_count  (retire_count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of {pc, ir} pairs plus plain state.
  logic [63:0] mq [$];
  logic [31:0] m_spc, m_sir, m_cpc, m_cir, m_cnt;
  bit          m_cvld, m_ovf, m_udf;

  task automatic model_reset();
    mq.delete();
    m_spc = 32'h0040_0000;
    m_sir = 32'h0;
    m_cpc = 32'h4443_6040;
    m_cir = 32'h8880_7704;
    m_cnt = 32'h0;
    m_cvld = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_edge(input bit cp, input bit ci, input bit pu, input bit co,
                            input bit fl, input logic [31:0] pc, input logic [31:0] ir);
    logic [63:0] e;
    int n;
    n = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      if (co) begin
        if (n == 0) m_udf = 1'b1;
        else begin
          e = mq.pop_front();
          m_cpc = e[63:32];
          m_cir = e[31:0];
          m_cnt = m_cnt + 32'd1;
          m_cvld = 1'b1;
        end
      end
      if (pu) begin
        if (n == DEPTH && !co) m_ovf = 1'b1;
        else mq.push_back({m_spc, m_sir});
      end
    end
    if (cp) m_spc = pc;
    if (ci) m_sir = ir;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":staged_pc"},    64'(staged_pc_out), 64'(m_spc));
    chk({ctx, ":commit_pc"},    64'(commit_pc_out), 64'(m_cpc));
    chk({ctx, ":commit_ir"},    64'(commit_ir_out), 64'(m_cir));
    chk({ctx, ":commit_valid"}, 64'(commit_valid),  64'(m_cvld));
    chk({ctx, ":occupancy"},    64'(occupancy),     64'(mq.size()));
    chk({ctx, ":full"},         64'(full),          64'(mq.size() == DEPTH));
    chk({ctx, ":empty"},        64'(empty),         64'(mq.size() == 0));
    chk({ctx, ":retire_count"}, 64'(retire_count),  64'(m_cnt));
    chk({ctx, ":overflow"},     64'(overflow),      64'(m_ovf));
    chk({ctx, ":underflow"},    64'(underflow),     64'(m_udf));
  endtask

  // Drive one falling edge worth of inputs, advance the model, then compare.
  task automatic step(input string ctx, input bit cp, input bit ci, input bit pu,
                      input bit co, input bit fl, input logic [31:0] pc, input logic [31:0] ir);
    capture_pc = cp; capture_ir = ci; push = pu; commit = co; flush = fl;
    pc_in = pc; ir_in = ir;
    @(negedge clk);
    model_edge(cp, ci, pu, co, fl, pc, ir);
    #2;
    check_all(ctx);
  endtask

  task automatic idle_inputs();
    capture_pc = 1'b0; capture_ir = 1'b0; push = 1'b0; commit = 1'b0; flush = 1'b0;
  endtask

  // Assert reset between edges, check immediately, release before next edge.
  task automatic do_reset(input string ctx);
    idle_inputs();
    rst = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset("reset");

    // Basic retire
    step("cap", 1, 1, 0, 0, 0, 32'h0040_0004, 32'h2008_000A);
    step("push", 0, 0, 1, 0, 0, 32'h0, 32'h0);
    step("commit", 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("basic_pc", 64'(commit_pc_out), 64'h0040_0004);
    chk("basic_ir", 64'(commit_ir_out), 64'h2008_000A);
    chk("basic_cnt", 64'(retire_count), 64'd1);

    // push+commit while empty: commit ignored, push lands
    step("pc_empty", 0, 0, 1, 1, 0, 32'h0, 32'h0);
    chk("pc_empty_udf", 64'(underflow), 64'd1);
    chk("pc_empty_occ", 64'(occupancy), 64'd1);
    chk("pc_empty_cpc", 64'(commit_pc_out), 64'h0040_0004);
    step("drain1", 0, 0, 0, 1, 0, 32'h0, 32'h0);

    // Fill and wrap, three rounds
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        step("fill_cap", 1, 1, 0, 0, 0, 32'h10 + 32'(4*k), 32'hA000 + 32'(16*r + k));
        step("fill_push", 0, 0, 1, 0, 0, 32'h0, 32'h0);
      end
      chk("fill_full", 64'(full), 64'd1);
      step("fill_ovf", 0, 0, 1, 0, 0, 32'h0, 32'h0);
      chk("fill_ovf_flag", 64'(overflow), 64'd1);
      for (int k = 0; k < 4; k++) begin
        step("drain", 0, 0, 0, 1, 0, 32'h0, 32'h0);
        chk("drain_order", 64'(commit_pc_out), 64'h10 + 64'(4*k));
      end
    end

    // push+commit while full
    for (int k = 0; k < 4; k++) begin
      step("f2_cap", 1, 1, 0, 0, 0, 32'h100 + 32'(k), 32'hB00 + 32'(k));
      step("f2_push", 0, 0, 1, 0, 0, 32'h0, 32'h0);
    end
    step("f2_cap5", 1, 0, 0, 0, 0, 32'h1FF, 32'h0);
    step("pc_full", 0, 0, 1, 1, 0, 32'h0, 32'h0);
    chk("pc_full_occ", 64'(occupancy), 64'd4);
    chk("pc_full_head", 64'(commit_pc_out), 64'h100);
    for (int k = 0; k < 4; k++) step("f2_drain", 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("f2_tail", 64'(commit_pc_out), 64'h1FF);

    // Flush with push, commit and capture on the same edge
    for (int k = 0; k < 3; k++) step("fl_push", 1, 0, 1, 0, 0, 32'h200 + 32'(k), 32'h0);
    step("flush", 1, 1, 1, 1, 1, 32'h0BAD_0001, 32'h0BAD_0002);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_staged", 64'(staged_pc_out), 64'h0BAD_0001);

    // Retire counter wrap
    step("wrap_push", 0, 0, 1, 0, 0, 32'h0, 32'h0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    m_cnt = 32'hFFFF_FFFF;
    chk("wrap_pre", 64'(retire_count), 64'hFFFF_FFFF);
    step("wrap_commit", 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("wrap_zero", 64'(retire_count), 64'd0);

    // Randomized traffic with occasional mid-run reset
    do_reset("rreset");
    for (int i = 0; i < 600; i++) begin
      if (i % 151 == 150) do_reset("rand_reset");
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 4), $urandom, $urandom);
    end

    // Async reset with two entries queued
    do_reset("pre_async");
    step("a_cap", 1, 1, 0, 0, 0, 32'h300, 32'h301);
    step("a_push1", 0, 0, 1, 0, 0, 32'h0, 32'h0);
    step("a_push2", 0, 0, 1, 0, 0, 32'h0, 32'h0);
    step("a_commit", 0, 0, 0, 1, 0, 32'h0, 32'h0);
    step("a_push3", 0, 0, 1, 0, 0, 32'h0, 32'h0);
    chk("a_occ", 64'(occupancy), 64'd2);
    do_reset("async");
    chk("async_cpc", 64'(commit_pc_out), 64'h4443_6040);
    chk("async_spc", 64'(staged_pc_out), 64'h0040_0000);
    step("post_async_commit", 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("post_async_udf", 64'(underflow), 64'd1);

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
